duck_sprite_draw: RTL and testbench
===================================

// Module: duck_sprite_draw
// PURPOSE
//  Positioned, scaled, flippable, animated sprite pixel source for the VGA path; successor to per-asset full-screen stretch examples.
//  Maps DrawX/DrawY to a sync-ROM address for NUM_FRAMES stacked frames; emits palette index plus opaque flag for top-level compositing.
//  Owns the animation sequencer; sprite attributes are latched once per video frame so there is no mid-frame tearing.
// PARAMETERS
//  SPR_W       68  sprite width, pixels
//  SPR_H       64  sprite height, pixels
//  NUM_FRAMES  6   animation frames, stored consecutively in ROM (frame f base = f*SPR_W*SPR_H)
//  ADDR_W      15  ROM address width; must satisfy 2^ADDR_W >= NUM_FRAMES*SPR_W*SPR_H
//  IDX_W       4   palette index width
//  TRANSP_IDX  0   palette index treated as transparent
//  FRAME_DIV   8   video frames per animation step (>=1)
// PORTS
//  vga_clk     in   1       pixel clock; single clock domain
//  reset       in   1       synchronous, active-high
//  DrawX       in   10      current pixel column
//  DrawY       in   10      current pixel row
//  blank       in   1       1 = active video (codebase polarity)
//  frame_tick  in   1       one-cycle pulse per video frame (vsync edge)
//  pos_x       in   10      sprite left edge, screen pixels
//  pos_y       in   10      sprite top edge, screen pixels
//  scale_sh    in   2       scale = 1<<scale_sh (1,2,4,8)
//  flip_h      in   1       1 = mirror horizontally
//  anim_start  in   1       pulse: restart animation at frame 0
//  anim_stop   in   1       pulse: freeze on current frame
//  anim_loop   in   1       1 = wrap after last frame, 0 = one-shot
//  rom_address out  ADDR_W  to sync ROM (q valid one vga_clk after address registered)
//  rom_q       in   IDX_W   ROM data
//  pix_index   out  IDX_W   palette index of current pixel
//  pix_on      out  1       1 = opaque sprite pixel in active video
//  cur_frame   out  3       frame being displayed
//  anim_busy   out  1       1 while in PLAY
//  anim_done   out  1       one-cycle pulse when a one-shot animation finishes
// BEHAVIOUR
//  Reset: all outputs and state 0; FSM=IDLE; latched attrs 0; div_cnt=0.
//  Attribute latch: on frame_tick, pos_x/pos_y/scale_sh/flip_h/cur_frame are copied into shadow regs; render path uses only shadow values.
//  Hit test (11-bit math, no wrap): dx=DrawX-px, dy=DrawY-py; hit = DrawX>=px && dx<(SPR_W<<sh) && DrawY>=py && dy<(SPR_H<<sh).
//  u=dx>>sh, v=dy>>sh; col = flip ? SPR_W-1-u : u; addr = frame*SPR_W*SPR_H + v*SPR_W + col.
//  Pipeline: E0 registers rom_address, hit, blank; E1 ROM registers rom_q, hit/blank delayed; E2 registers outputs.
//  Outputs therefore reflect DrawX/DrawY sampled 2 edges earlier (latency 2); throughput 1 pixel/clk.
//  pix_on = hit & blank & (rom_q != TRANSP_IDX); pix_index = rom_q when pix_on, else 0.
//  When not hit: rom_address = 0.
//  FSM IDLE: anim_start -> PLAY (frame=0, div_cnt=0).
//  FSM PLAY: on frame_tick, div_cnt++; when div_cnt==FRAME_DIV-1, div_cnt=0 and step the frame.
//   Step on last frame: anim_loop -> frame 0, stay PLAY; otherwise -> DONE, anim_done=1 for one cycle, frame held at NUM_FRAMES-1.
//  FSM PLAY: anim_stop -> IDLE, frame held.
//  FSM DONE: anim_start -> PLAY; anim_stop -> IDLE.
//  Simultaneous events: anim_start beats anim_stop beats frame_tick step.
//   Frame stepped on tick T is displayed from tick T+1 (latched at the next tick).
//  anim_busy = (state==PLAY).
//  reset at any time: pipeline and FSM cleared next edge; pix_on=0 from that edge on.
// TESTING
//  Defaults, px=100, py=50, sh=0, frame 0, tick then scan DrawY=50: DrawX=99 -> pix_on=0; DrawX=100 -> rom_address=0, 2 clk later pix_on iff rom_q!=0.
//  flip_h=1, DrawX=100, DrawY=50 -> rom_address=67; sh=1, DrawX=102 -> u=1 (rom_address=1, or 66 with flip); DrawX=236 -> miss.
//  anim_start, anim_loop=0, FRAME_DIV=2, 12 ticks -> cur_frame 0..5, anim_done pulses once, FSM in DONE, frame stays 5.
//  anim_loop=1, same stimulus -> frame wraps 5->0, anim_done never asserts, anim_busy stays 1.
//  anim_start+anim_stop same cycle -> PLAY at frame 0; blank=0 over a hit region -> pix_on=0.
//  Assert reset mid-scan and mid-animation -> all outputs 0 next edge; state IDLE; no anim_done pulse.

Source files
------------

// File: rtl/duck_sprite_draw.sv
// rtl/duck_sprite_draw.sv - positioned, scaled, flippable, animated sprite pixel source
// Shadow attributes are only updated on frame_tick, so a frame is always drawn with one set of values.
module duck_sprite_draw #(
  parameter int SPR_W      = 68,
  parameter int SPR_H      = 64,
  parameter int NUM_FRAMES = 6,
  parameter int ADDR_W     = 15,
  parameter int IDX_W      = 4,
  parameter int TRANSP_IDX = 0,
  parameter int FRAME_DIV  = 8
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_tick,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [1:0]        scale_sh,
  input  logic              flip_h,
  input  logic              anim_start,
  input  logic              anim_stop,
  input  logic              anim_loop,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pix_index,
  output logic              pix_on,
  output logic [2:0]        cur_frame,
  output logic              anim_busy,
  output logic              anim_done
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

  localparam int              DIV_W      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(FRAME_DIV - 1);
  localparam logic [2:0]      LAST_FRAME = 3'(NUM_FRAMES - 1);

  state_t            state, state_nx;
  logic [2:0]        frame, frame_nx;
  logic [DIV_W-1:0]  div_cnt, div_nx;
  logic              done_nx;

  logic [9:0]        sh_x, sh_y;
  logic [1:0]        sh_scale;
  logic              sh_flip;
  logic [2:0]        sh_frame;

  logic [10:0]       dx, dy, span_w, span_h, u, v, col;
  logic              hit;
  logic [ADDR_W-1:0] addr_calc;
  logic              hit_e0, blank_e0, hit_e1, blank_e1;
  logic              opaque;

  // Render-side geometry, 11-bit so that edges near the screen limit never wrap.
  always_comb begin
    dx        = {1'b0, DrawX} - {1'b0, sh_x};
    dy        = {1'b0, DrawY} - {1'b0, sh_y};
    span_w    = 11'(SPR_W) << sh_scale;
    span_h    = 11'(SPR_H) << sh_scale;
    hit       = (DrawX >= sh_x) && (dx < span_w) && (DrawY >= sh_y) && (dy < span_h);
    u         = dx >> sh_scale;
    v         = dy >> sh_scale;
    col       = sh_flip ? (11'(SPR_W - 1) - u) : u;
    addr_calc = ADDR_W'(sh_frame) * ADDR_W'(SPR_W * SPR_H)
              + ADDR_W'(v) * ADDR_W'(SPR_W)
              + ADDR_W'(col);
  end

  assign opaque = hit_e1 && blank_e1 && (rom_q != IDX_W'(TRANSP_IDX));

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_address <= '0;
      hit_e0      <= 1'b0;
      blank_e0    <= 1'b0;
      hit_e1      <= 1'b0;
      blank_e1    <= 1'b0;
      pix_on      <= 1'b0;
      pix_index   <= '0;
    end else begin
      rom_address <= hit ? addr_calc : '0;
      hit_e0      <= hit;
      blank_e0    <= blank;
      hit_e1      <= hit_e0;
      blank_e1    <= blank_e0;
      pix_on      <= opaque;
      pix_index   <= opaque ? rom_q : '0;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      sh_x     <= '0;
      sh_y     <= '0;
      sh_scale <= '0;
      sh_flip  <= 1'b0;
      sh_frame <= '0;
    end else if (frame_tick) begin
      sh_x     <= pos_x;
      sh_y     <= pos_y;
      sh_scale <= scale_sh;
      sh_flip  <= flip_h;
      sh_frame <= frame;
    end
  end

  assign cur_frame = sh_frame;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state     <= S_IDLE;
      frame     <= '0;
      div_cnt   <= '0;
      anim_done <= 1'b0;
    end else begin
      state     <= state_nx;
      frame     <= frame_nx;
      div_cnt   <= div_nx;
      anim_done <= done_nx;
    end
  end

  // Priority inside each state: start, then stop, then the tick step.
  always_comb begin
    state_nx = state;
    frame_nx = frame;
    div_nx   = div_cnt;
    done_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (anim_start) begin
          state_nx = S_PLAY;
          frame_nx = '0;
          div_nx   = '0;
        end
      end
      S_PLAY: begin
        if (anim_start) begin
          frame_nx = '0;
          div_nx   = '0;
        end else if (anim_stop) begin
          state_nx = S_IDLE;
        end else if (frame_tick) begin
          if (div_cnt == DIV_LAST) begin
            div_nx = '0;
            if (frame == LAST_FRAME) begin
              if (anim_loop) begin
                frame_nx = '0;
              end else begin
                state_nx = S_DONE;
                done_nx  = 1'b1;
              end
            end else begin
              frame_nx = frame + 3'd1;
            end
          end else begin
            div_nx = div_cnt + DIV_W'(1);
          end
        end
      end
      S_DONE: begin
        if (anim_start) begin
          state_nx = S_PLAY;
          frame_nx = '0;
          div_nx   = '0;
        end else if (anim_stop) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    anim_busy = (state == S_PLAY);
  end

endmodule

// File: tb/tb_duck_sprite_draw.sv
// tb/tb_duck_sprite_draw.sv - scoreboard bench for duck_sprite_draw
module tb_duck_sprite_draw;
  localparam int SPR_W      = 68;
  localparam int SPR_H      = 64;
  localparam int NUM_FRAMES = 6;
  localparam int ADDR_W     = 15;
  localparam int IDX_W      = 4;
  localparam int FRAME_DIV  = 2;

  logic              vga_clk = 1'b0;
  logic              reset;
  logic [9:0]        DrawX, DrawY, pos_x, pos_y;
  logic              blank, frame_tick;
  logic [1:0]        scale_sh;
  logic              flip_h, anim_start, anim_stop, anim_loop;
  logic [ADDR_W-1:0] rom_address;
  logic [IDX_W-1:0]  rom_q;
  logic [IDX_W-1:0]  pix_index;
  logic              pix_on;
  logic [2:0]        cur_frame;
  logic              anim_busy, anim_done;

  duck_sprite_draw #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_FRAMES(NUM_FRAMES), .ADDR_W(ADDR_W),
    .IDX_W(IDX_W), .TRANSP_IDX(0), .FRAME_DIV(FRAME_DIV)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_tick(frame_tick), .pos_x(pos_x), .pos_y(pos_y), .scale_sh(scale_sh),
    .flip_h(flip_h), .anim_start(anim_start), .anim_stop(anim_stop), .anim_loop(anim_loop),
    .rom_address(rom_address), .rom_q(rom_q), .pix_index(pix_index), .pix_on(pix_on),
    .cur_frame(cur_frame), .anim_busy(anim_busy), .anim_done(anim_done)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic logic [IDX_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
    return a[3:0] ^ a[7:4];
  endfunction

  always @(posedge vga_clk) rom_q <= rom_fn(rom_address);

  typedef struct {
    int          due;
    logic [31:0] addr;
    logic [31:0] on;
    logic [31:0] idx;
  } exp_t;

  exp_t addr_q[$];
  exp_t pix_q[$];

  int checks = 0, errors = 0, cyc = 0, done_cnt = 0;
  int m_px, m_py, m_sh, m_flip, m_cur, m_frame, m_div, m_state;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clk_step();
    exp_t e;
    @(posedge vga_clk);
    cyc++;
    #1;
    if (anim_done === 1'b1) done_cnt++;
    while (addr_q.size() > 0 && addr_q[0].due == cyc) begin
      e = addr_q.pop_front();
      check("rom_address", 32'(rom_address), e.addr);
    end
    while (pix_q.size() > 0 && pix_q[0].due == cyc) begin
      e = pix_q.pop_front();
      check("pix_on", 32'(pix_on), e.on);
      check("pix_index", 32'(pix_index), e.idx);
    end
  endtask

  task automatic pix(input int x, input int y, input logic b);
    int   dx, dy, u, v, col, addr;
    logic hit, on;
    exp_t e;
    dx   = x - m_px;
    dy   = y - m_py;
    hit  = (x >= m_px) && (dx < (SPR_W << m_sh)) && (y >= m_py) && (dy < (SPR_H << m_sh));
    addr = 0;
    if (hit) begin
      u    = dx >> m_sh;
      v    = dy >> m_sh;
      col  = (m_flip != 0) ? (SPR_W - 1 - u) : u;
      addr = m_cur * SPR_W * SPR_H + v * SPR_W + col;
    end
    on      = hit && b && (rom_fn(ADDR_W'(addr)) != 0);
    DrawX   = 10'(x);
    DrawY   = 10'(y);
    blank   = b;
    e.due   = cyc + 1;
    e.addr  = 32'(addr);
    e.on    = 32'(on);
    e.idx   = on ? 32'(rom_fn(ADDR_W'(addr))) : 32'd0;
    addr_q.push_back(e);
    e.due   = cyc + 3;
    pix_q.push_back(e);
    clk_step();
  endtask

  task automatic flush();
    repeat (3) pix(0, 0, 1'b0);
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    m_px = int'(pos_x); m_py = int'(pos_y); m_sh = int'(scale_sh); m_flip = int'(flip_h);
    m_cur = m_frame;
    if (m_state == 1) begin
      if (m_div == FRAME_DIV - 1) begin
        m_div = 0;
        if (m_frame == NUM_FRAMES - 1) begin
          if (anim_loop) m_frame = 0;
          else m_state = 2;
        end else begin
          m_frame++;
        end
      end else begin
        m_div++;
      end
    end
    clk_step();
    frame_tick = 1'b0;
  endtask

  task automatic set_attr(input int x, input int y, input int sh, input int fl);
    pos_x = 10'(x); pos_y = 10'(y); scale_sh = 2'(sh); flip_h = fl[0];
    do_tick();
  endtask

  task automatic start_anim(input logic with_stop);
    anim_start = 1'b1;
    anim_stop  = with_stop;
    m_state = 1; m_frame = 0; m_div = 0;
    clk_step();
    anim_start = 1'b0;
    anim_stop  = 1'b0;
  endtask

  task automatic stop_anim();
    anim_stop = 1'b1;
    m_state = 0;
    clk_step();
    anim_stop = 1'b0;
  endtask

  task automatic model_reset();
    m_px = 0; m_py = 0; m_sh = 0; m_flip = 0; m_cur = 0; m_frame = 0; m_div = 0; m_state = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, 32'(rom_address), 0);
    check({tag, "_pix_on"}, 32'(pix_on), 0);
    check({tag, "_pix_index"}, 32'(pix_index), 0);
    check({tag, "_cur_frame"}, 32'(cur_frame), 0);
    check({tag, "_busy"}, 32'(anim_busy), 0);
    check({tag, "_done"}, 32'(anim_done), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int px, py, sh, span_x, span_y;
    reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b0; frame_tick = 1'b0;
    pos_x = '0; pos_y = '0; scale_sh = '0; flip_h = 1'b0;
    anim_start = 1'b0; anim_stop = 1'b0; anim_loop = 1'b0;
    model_reset();
    clk_step();
    clk_step();
    check_all_zero("reset");
    reset = 1'b0;

    set_attr(100, 50, 0, 0);
    for (int x = 98; x <= 104; x++) pix(x, 50, 1'b1);
    pix(101, 50, 1'b1);
    check("addr_u1", 32'(rom_address), 1);
    for (int x = 166; x <= 169; x++) pix(x, 50, 1'b1);
    pix(100, 113, 1'b1);
    pix(100, 114, 1'b1);
    pix(100, 49, 1'b1);
    flush();

    set_attr(100, 50, 0, 1);
    pix(100, 50, 1'b1);
    check("addr_flip", 32'(rom_address), 67);
    pix(167, 50, 1'b1);
    pix(101, 51, 1'b1);
    flush();

    set_attr(100, 50, 1, 0);
    pix(102, 50, 1'b1);
    check("addr_scale2", 32'(rom_address), 1);
    set_attr(100, 50, 1, 1);
    pix(102, 50, 1'b1);
    check("addr_scale2_flip", 32'(rom_address), 66);
    pix(236, 50, 1'b1);
    check("addr_miss_236", 32'(rom_address), 0);
    pix(235, 177, 1'b1);
    pix(235, 178, 1'b1);
    for (int x = 100; x <= 106; x++) pix(x, 52, 1'b0);
    flush();

    repeat (6) begin
      px = int'($urandom_range(0, 400));
      py = int'($urandom_range(0, 400));
      sh = int'($urandom_range(0, 3));
      set_attr(px, py, sh, int'($urandom_range(0, 1)));
      span_x = SPR_W << sh;
      span_y = SPR_H << sh;
      repeat (20) begin
        pix((px < 2) ? px + int'($urandom_range(0, span_x + 1))
                     : px - 2 + int'($urandom_range(0, span_x + 3)),
            py + int'($urandom_range(0, span_y + 1)),
            $urandom_range(0, 3) != 0);
      end
    end
    flush();

    anim_loop = 1'b0;
    done_cnt = 0;
    start_anim(1'b0);
    check("busy_after_start", 32'(anim_busy), 1);
    for (int i = 1; i <= 12; i++) begin
      do_tick();
      check("oneshot_cur_frame", 32'(cur_frame), 32'(m_cur));
      check("oneshot_busy", 32'(anim_busy), 32'(m_state == 1));
      clk_step();
    end
    repeat (2) clk_step();
    check("oneshot_done_once", 32'(done_cnt), 1);
    check("oneshot_idle_busy", 32'(anim_busy), 0);
    do_tick();
    check("oneshot_hold5", 32'(cur_frame), 5);

    set_attr(100, 50, 0, 0);
    pix(100, 50, 1'b1);
    check("addr_frame5", 32'(rom_address), 21760);
    pix(101, 51, 1'b1);
    flush();

    anim_loop = 1'b1;
    done_cnt = 0;
    start_anim(1'b0);
    for (int i = 1; i <= 14; i++) begin
      do_tick();
      check("loop_cur_frame", 32'(cur_frame), 32'(m_cur));
      check("loop_busy", 32'(anim_busy), 1);
      if (i == 13) check("loop_wrap", 32'(cur_frame), 0);
      clk_step();
    end
    check("loop_no_done", 32'(done_cnt), 0);

    start_anim(1'b1);
    check("start_beats_stop_busy", 32'(anim_busy), 1);
    do_tick();
    do_tick();
    check("start_beats_stop_frame", 32'(cur_frame), 0);
    stop_anim();
    check("stop_busy", 32'(anim_busy), 0);
    do_tick();
    check("stop_hold_frame", 32'(cur_frame), 32'(m_cur));

    anim_loop = 1'b0;
    start_anim(1'b0);
    repeat (11) do_tick();
    pix(110, 60, 1'b1);
    pix(111, 60, 1'b1);
    addr_q.delete();
    pix_q.delete();
    done_cnt = 0;
    reset = 1'b1;
    frame_tick = 1'b1;
    clk_step();
    frame_tick = 1'b0;
    model_reset();
    check_all_zero("midreset");
    clk_step();
    reset = 1'b0;
    repeat (3) clk_step();
    check("midreset_no_done", 32'(done_cnt), 0);
    check("midreset_idle", 32'(anim_busy), 0);

    set_attr(100, 50, 0, 0);
    for (int x = 100; x <= 104; x++) pix(x, 53, 1'b1);
    flush();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
